dram_req_ctrl: RTL
==================

// Module: dram_req_ctrl
// PURPOSE
//  Initiator for the single-port RAM interface (en/wen/addr/data, sync 1-cycle read, read-first, no byte enables).
//  Converts core load/store requests (valid/ready, byte address, size) into RAM accesses; sub-word stores use read-modify-write.
//  Returns one response per request over a valid/ready channel. Sits between the core LSU and the data RAM; one request in flight.
// PARAMETERS
//  ADDR_W     32    request byte-address width
//  RAM_DEPTH  1024  RAM depth in 32-bit words; localparam RAM_AW = $clog2(RAM_DEPTH) = RAM address width
// PORTS
//  clk          in   1       clock
//  aresetn      in   1       reset, asynchronous, active-low
//  i_req_valid  in   1       request valid
//  o_req_ready  out  1       request ready (registered)
//  i_req_wen    in   1       1 = store, 0 = load
//  i_req_size   in   2       00 byte, 01 half, 10 word, 11 reserved
//  i_req_addr   in   ADDR_W  byte address
//  i_req_wdata  in   32      store data, right-aligned
//  o_rsp_valid  out  1       response valid
//  i_rsp_ready  in   1       response ready
//  o_rsp_rdata  out  32      load data, right-aligned, zero-extended; 0 for stores
//  o_rsp_err    out  1       access error (see CONFIGURATION)
//  o_ram_en     out  1       RAM enable
//  o_ram_wen    out  1       RAM write enable
//  o_ram_addr   out  RAM_AW  RAM word address = i_req_addr[RAM_AW+1:2]; upper bits ignored (wrap)
//  o_ram_data   out  32      RAM write data
//  i_ram_data   in   32      RAM read data (valid the cycle after the edge that samples en=1)
// BEHAVIOUR
//  - Reset (async): state IDLE; every output 0, o_req_ready included; o_req_ready rises on first clk edge after release.
//  - All outputs registered. Accept = i_req_valid & o_req_ready at edge E0; o_req_ready drops at E0.
//  - FSM: IDLE, ISSUE, DATA, WRITE, RSP. o_ram_en is high for exactly one cycle per RAM command.
//    Word store : E0 drive en=1,wen=1,data=wdata -> ISSUE; E1 o_rsp_valid=1 -> RSP.
//    Load       : E0 drive en=1,wen=0 -> ISSUE; E1 -> DATA; E2 capture i_ram_data, lane-extract, o_rsp_valid=1 -> RSP.
//    Sub-word st: as load to DATA; E2 merge lane into i_ram_data, drive en=1,wen=1 -> WRITE; E3 o_rsp_valid=1 -> RSP.
//  - Lanes: byte at addr[1:0] -> bits [8*addr[1:0]+:8]; half at addr[1] -> bits [16*addr[1]+:16]; other bits preserved.
//  - RSP: o_rsp_valid, o_rsp_rdata, o_rsp_err held stable until i_rsp_ready; on handshake o_rsp_valid=0, o_req_ready=1 -> IDLE.
//  - No RAM command is issued in RSP or IDLE; i_req_* ignored while o_req_ready=0.
//  - Reset mid-operation: o_ram_en cleared immediately; a RAM write not yet sampled is dropped; RMW aborted leaves word unchanged.
//  - Back-to-back: min request spacing = latency + 1 cycle (ready returns on response handshake edge).
// CONFIGURATION
//  Macro DRAM_REQ_MISALIGN_CHK_EN:
//  - Defined: half with addr[0]=1, word with addr[1:0]!=0, or size 11 -> no RAM access; E0 -> RSP, o_rsp_err=1, rdata=0.
//  - Undefined: o_rsp_err tied 0; half ignores addr[0], word ignores addr[1:0]; size 11 treated as word.
// TESTING
//  1. Word store 0xDEADBEEF @0x10, then word load @0x10 -> o_rsp_valid 1 cycle after store accept, 2 after load; rdata 0xDEADBEEF.
//  2. Word 0x11223344 @0x10; byte store 0xA5 @0x13 -> RAM write at E2, word 0xA5223344; byte load @0x13 -> rdata 0x000000A5.
//  3. Half store 0xBEEF @0x12 over 0xA5223344 -> word 0xBEEF3344, rsp at E3; half load @0x12 -> 0x0000BEEF.
//  4. Load with i_rsp_ready=0 for 10 cycles -> rsp valid/rdata stable, o_req_ready=0, o_ram_en=0 throughout; ready=1 cycle after handshake.
//  5. Half load @0x11: with macro -> o_rsp_err=1, rdata 0, no o_ram_en pulse; without -> reads word 0x10 lower half, err=0.
//  6. Assert aresetn low in DATA of byte store @0x13 -> outputs 0 at once, no RAM write, word @0x10 unchanged; o_req_ready=1 after release.
//  7. Addr 0x1010 with RAM_DEPTH=1024 -> o_ram_addr 0x004 (wrap).

Source files
------------

// File: rtl/dram_req_ctrl.sv
// Core load/store to single-port RAM request controller; sub-word stores use read-modify-write.
// Optional `DRAM_REQ_MISALIGN_CHK_EN: reject misaligned half/word and reserved size with o_rsp_err.
//
// state   | meaning
// IDLE    | ready for a request (ready raised on first edge after reset)
// ISSUE   | RAM command issued at accept edge
// DATA    | RAM read data valid on i_ram_data
// WRITE   | merged word written back (sub-word store)
// RSP     | response held until i_rsp_ready
module dram_req_ctrl #(
    parameter int ADDR_W    = 32,
    parameter int RAM_DEPTH = 1024,
    localparam int RAM_AW   = $clog2(RAM_DEPTH)
) (
    input  logic              clk,
    input  logic              aresetn,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_wen,
    input  logic [1:0]        i_req_size,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output logic              o_ram_en,
    output logic              o_ram_wen,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic [31:0]       o_ram_data,
    input  logic [31:0]       i_ram_data
);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DATA, S_WRITE, S_RSP} state_t;

    localparam logic [1:0] K_BYTE = 2'b00;
    localparam logic [1:0] K_HALF = 2'b01;
    localparam logic [1:0] K_WORD = 2'b10;

    state_t            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_wen_q, ram_wen_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_data_q, ram_data_d;
    logic              st_wen_q, st_wen_d;
    logic [1:0]        kind_q, kind_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [1:0]        req_kind;
    logic              req_bad;
    logic              unused_addr_hi;

    // Upper address bits beyond the RAM are intentionally dropped (address wraps).
    assign unused_addr_hi = ^i_req_addr[ADDR_W-1:RAM_AW+2];

    function automatic logic [31:0] lane_extract(input logic [31:0] w, input logic [1:0] kind,
                                                 input logic [1:0] off);
        logic [31:0] r;
        r = w;
        if (kind == K_BYTE)
            r = {24'd0, w[{off, 3'b000} +: 8]};
        else if (kind == K_HALF)
            r = {16'd0, w[{off[1], 4'b0000} +: 16]};
        return r;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] w, input logic [31:0] d,
                                               input logic [1:0] kind, input logic [1:0] off);
        logic [31:0] r;
        r = w;
        if (kind == K_BYTE)
            r[{off, 3'b000} +: 8] = d[7:0];
        else if (kind == K_HALF)
            r[{off[1], 4'b0000} +: 16] = d[15:0];
        else
            r = d;
        return r;
    endfunction

    always_comb begin
        req_kind = i_req_size[1] ? K_WORD : (i_req_size[0] ? K_HALF : K_BYTE);
`ifdef DRAM_REQ_MISALIGN_CHK_EN
        req_bad = (i_req_size == 2'b11) ||
                  (i_req_size == 2'b01 && i_req_addr[0]) ||
                  (i_req_size == 2'b10 && i_req_addr[1:0] != 2'b00);
`else
        req_bad = 1'b0;
`endif
    end

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        ram_en_d    = 1'b0;
        ram_wen_d   = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        st_wen_d    = st_wen_q;
        kind_d      = kind_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (!req_ready_q) begin
                    req_ready_d = 1'b1;
                end else if (i_req_valid) begin
                    req_ready_d = 1'b0;
                    st_wen_d    = i_req_wen;
                    kind_d      = req_kind;
                    off_d       = i_req_addr[1:0];
                    wdata_d     = i_req_wdata;
                    ram_addr_d  = i_req_addr[RAM_AW+1:2];
                    if (req_bad) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = 32'd0;
                        state_d     = S_RSP;
                    end else begin
                        // Sub-word stores start with a read; only word stores write directly.
                        ram_en_d   = 1'b1;
                        ram_wen_d  = i_req_wen && (req_kind == K_WORD);
                        ram_data_d = i_req_wdata;
                        state_d    = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                if (st_wen_q && kind_q == K_WORD) begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = 32'd0;
                    state_d     = S_RSP;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (st_wen_q) begin
                    ram_en_d   = 1'b1;
                    ram_wen_d  = 1'b1;
                    ram_data_d = lane_merge(i_ram_data, wdata_q, kind_q, off_q);
                    state_d    = S_WRITE;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = lane_extract(i_ram_data, kind_q, off_q);
                    state_d     = S_RSP;
                end
            end
            S_WRITE: begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = 32'd0;
                state_d     = S_RSP;
            end
            S_RSP: begin
                if (i_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'd0;
                    rsp_err_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_wen_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= 32'd0;
            st_wen_q    <= 1'b0;
            kind_q      <= K_BYTE;
            off_q       <= 2'b00;
            wdata_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            ram_en_q    <= ram_en_d;
            ram_wen_q   <= ram_wen_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            st_wen_q    <= st_wen_d;
            kind_q      <= kind_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
        end
    end

    assign o_req_ready = req_ready_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_ram_en    = ram_en_q;
    assign o_ram_wen   = ram_wen_q;
    assign o_ram_addr  = ram_addr_q;
    assign o_ram_data  = ram_data_q;

endmodule
